// File: rtl/qr_result_drain.sv
// Captures R (32 words) and Q (64 words) from qr_cordic, then streams them R-then-Q on done.
// Latency: out_valid rises one cycle after the done rising edge; one word per accepted cycle.
// Backpressure: out_ready low holds every output stable; writes arriving while draining are dropped.
module qr_result_drain #(
  parameter int OUT_WIDTH = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_R,
  input  logic signed [OUT_WIDTH-1:0] wr_R_data,
  input  logic [2:0]                  wr_R_row_addr,
  input  logic [1:0]                  wr_R_col_addr,
  input  logic                        wr_Q_1,
  input  logic                        wr_Q_2,
  input  logic                        wr_Q_3,
  input  logic                        wr_Q_4,
  input  logic                        wr_Q_5,
  input  logic                        wr_Q_6,
  input  logic                        wr_Q_7,
  input  logic                        wr_Q_8,
  input  logic signed [OUT_WIDTH-1:0] wr_Q_data_1,
  input  logic signed [OUT_WIDTH-1:0] wr_Q_data_2,
  input  logic signed [OUT_WIDTH-1:0] wr_Q_data_3,
  input  logic signed [OUT_WIDTH-1:0] wr_Q_data_4,
  input  logic signed [OUT_WIDTH-1:0] wr_Q_data_5,
  input  logic signed [OUT_WIDTH-1:0] wr_Q_data_6,
  input  logic signed [OUT_WIDTH-1:0] wr_Q_data_7,
  input  logic signed [OUT_WIDTH-1:0] wr_Q_data_8,
  input  logic [2:0]                  wr_Q_addr_1,
  input  logic [2:0]                  wr_Q_addr_2,
  input  logic [2:0]                  wr_Q_addr_3,
  input  logic [2:0]                  wr_Q_addr_4,
  input  logic [2:0]                  wr_Q_addr_5,
  input  logic [2:0]                  wr_Q_addr_6,
  input  logic [2:0]                  wr_Q_addr_7,
  input  logic [2:0]                  wr_Q_addr_8,
  input  logic                        done,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_sel,
  output logic [5:0]                  out_index,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        drop_err
);

  typedef enum logic [1:0] {CAPTURE, DRAIN_R, DRAIN_Q, FIN} state_t;

  state_t                      r_state;
  logic [5:0]                  r_ptr;
  logic                        r_sel;
  logic                        r_valid;
  logic                        r_busy;
  logic                        r_frame_done;
  logic                        r_drop_err;
  logic                        r_done_d;
  logic signed [OUT_WIDTH-1:0] r_rmem [32];
  logic signed [OUT_WIDTH-1:0] r_qmem [64];

  logic [7:0]                  w_q_we;
  logic signed [OUT_WIDTH-1:0] w_q_dat [8];
  logic [2:0]                  w_q_adr [8];
  logic                        w_capture;
  logic                        w_any_wr;
  logic                        w_start;
  logic                        w_xfer;

  // Gather the eight Q row ports so row k maps to Q_MEM rows (k-1)*8.
  assign w_q_we     = {wr_Q_8, wr_Q_7, wr_Q_6, wr_Q_5, wr_Q_4, wr_Q_3, wr_Q_2, wr_Q_1};
  assign w_q_dat[0] = wr_Q_data_1;
  assign w_q_dat[1] = wr_Q_data_2;
  assign w_q_dat[2] = wr_Q_data_3;
  assign w_q_dat[3] = wr_Q_data_4;
  assign w_q_dat[4] = wr_Q_data_5;
  assign w_q_dat[5] = wr_Q_data_6;
  assign w_q_dat[6] = wr_Q_data_7;
  assign w_q_dat[7] = wr_Q_data_8;
  assign w_q_adr[0] = wr_Q_addr_1;
  assign w_q_adr[1] = wr_Q_addr_2;
  assign w_q_adr[2] = wr_Q_addr_3;
  assign w_q_adr[3] = wr_Q_addr_4;
  assign w_q_adr[4] = wr_Q_addr_5;
  assign w_q_adr[5] = wr_Q_addr_6;
  assign w_q_adr[6] = wr_Q_addr_7;
  assign w_q_adr[7] = wr_Q_addr_8;

  assign w_capture = (r_state == CAPTURE);
  assign w_any_wr  = wr_R | (|w_q_we);
  assign w_start   = w_capture && done && !r_done_d;
  assign w_xfer    = r_valid && out_ready;

  // Memories only accept writes while capturing, so their contents are frozen during a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_rmem[i] <= '0;
      for (int i = 0; i < 64; i++) r_qmem[i] <= '0;
    end else if (w_capture) begin
      if (wr_R) r_rmem[{wr_R_row_addr, wr_R_col_addr}] <= wr_R_data;
      for (int k = 0; k < 8; k++) begin
        if (w_q_we[k]) r_qmem[{3'(k), w_q_adr[k]}] <= w_q_dat[k];
      end
    end
  end

  // Drain sequencer: CAPTURE -> DRAIN_R (32 words) -> DRAIN_Q (64 words) -> FIN -> CAPTURE.
  // Done history resets to 1 so a done level held through reset cannot start a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= CAPTURE;
      r_ptr        <= '0;
      r_sel        <= 1'b0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_drop_err   <= 1'b0;
      r_done_d     <= 1'b1;
    end else begin
      r_done_d     <= done;
      r_frame_done <= 1'b0;
      if (!w_capture && w_any_wr) r_drop_err <= 1'b1;
      case (r_state)
        CAPTURE: begin
          if (w_start) begin
            r_state <= DRAIN_R;
            r_ptr   <= '0;
            r_sel   <= 1'b0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        DRAIN_R: begin
          if (w_xfer) begin
            if (r_ptr == 6'd31) begin
              r_state <= DRAIN_Q;
              r_ptr   <= '0;
              r_sel   <= 1'b1;
            end else begin
              r_ptr <= r_ptr + 6'd1;
            end
          end
        end
        DRAIN_Q: begin
          if (w_xfer) begin
            if (r_ptr == 6'd63) begin
              r_state      <= FIN;
              r_ptr        <= '0;
              r_sel        <= 1'b0;
              r_valid      <= 1'b0;
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
            end else begin
              r_ptr <= r_ptr + 6'd1;
            end
          end
        end
        default: begin
          r_state <= CAPTURE;
        end
      endcase
    end
  end

  assign out_valid  = r_valid;
  assign out_sel    = r_sel;
  assign out_index  = r_ptr;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign drop_err   = r_drop_err;
  assign out_data   = !r_valid ? '0 : (r_sel ? r_qmem[r_ptr] : r_rmem[r_ptr[4:0]]);

endmodule

// File: tb/tb_qr_result_drain.sv
// Self-checking bench for qr_result_drain: randomized captures checked against an array model.
// Latency: one word per cycle with out_ready high; drains run under a cycle budget.
// Backpressure: out_ready is toggled randomly and output stability is recorded while it is low.
module tb_qr_result_drain;
  localparam int W = 12;

  logic                clk = 1'b0;
  logic                rst;
  logic                wr_R;
  logic signed [W-1:0] wr_R_data;
  logic [2:0]          wr_R_row_addr;
  logic [1:0]          wr_R_col_addr;
  logic                q_we  [8];
  logic signed [W-1:0] q_dat [8];
  logic [2:0]          q_adr [8];
  logic                done;
  logic                out_ready;
  logic                out_valid;
  logic signed [W-1:0] out_data;
  logic                out_sel;
  logic [5:0]          out_index;
  logic                busy;
  logic                frame_done;
  logic                drop_err;

  // Reference model: plain arrays of the two matrices.
  logic signed [W-1:0] mr [32];
  logic signed [W-1:0] mq [64];

  // Observations recorded by run_frame.
  logic signed [W-1:0] obs_dat [$];
  logic                obs_sel [$];
  logic [5:0]          obs_idx [$];
  int                  obs_unstable, obs_fd_early, obs_gaps, obs_cycles, obs_timeout;
  logic                obs_fd_after, obs_valid_after, obs_busy_after, obs_fd_next;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  qr_result_drain #(.OUT_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .wr_R(wr_R), .wr_R_data(wr_R_data), .wr_R_row_addr(wr_R_row_addr), .wr_R_col_addr(wr_R_col_addr),
    .wr_Q_1(q_we[0]), .wr_Q_2(q_we[1]), .wr_Q_3(q_we[2]), .wr_Q_4(q_we[3]),
    .wr_Q_5(q_we[4]), .wr_Q_6(q_we[5]), .wr_Q_7(q_we[6]), .wr_Q_8(q_we[7]),
    .wr_Q_data_1(q_dat[0]), .wr_Q_data_2(q_dat[1]), .wr_Q_data_3(q_dat[2]), .wr_Q_data_4(q_dat[3]),
    .wr_Q_data_5(q_dat[4]), .wr_Q_data_6(q_dat[5]), .wr_Q_data_7(q_dat[6]), .wr_Q_data_8(q_dat[7]),
    .wr_Q_addr_1(q_adr[0]), .wr_Q_addr_2(q_adr[1]), .wr_Q_addr_3(q_adr[2]), .wr_Q_addr_4(q_adr[3]),
    .wr_Q_addr_5(q_adr[4]), .wr_Q_addr_6(q_adr[5]), .wr_Q_addr_7(q_adr[6]), .wr_Q_addr_8(q_adr[7]),
    .done(done), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_index(out_index),
    .busy(busy), .frame_done(frame_done), .drop_err(drop_err)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes;
    wr_R = 1'b0;
    for (int k = 0; k < 8; k++) q_we[k] = 1'b0;
  endtask

  task automatic clear_model;
    for (int i = 0; i < 32; i++) mr[i] = '0;
    for (int i = 0; i < 64; i++) mq[i] = '0;
  endtask

  // n cycles of random writes to random addresses; the model keeps the last value per address.
  task automatic rand_writes(input int n);
    int idx, a;
    repeat (n) begin
      idx = $urandom_range(0, 31);
      wr_R          = 1'($urandom_range(0, 1));
      wr_R_row_addr = 3'(idx / 4);
      wr_R_col_addr = 2'(idx % 4);
      wr_R_data     = W'($urandom);
      if (wr_R) mr[idx] = wr_R_data;
      for (int k = 0; k < 8; k++) begin
        a        = $urandom_range(0, 7);
        q_we[k]  = 1'($urandom_range(0, 1));
        q_adr[k] = 3'(a);
        q_dat[k] = W'($urandom);
        if (q_we[k]) mq[k * 8 + a] = q_dat[k];
      end
      step;
    end
    clear_strobes;
  endtask

  task automatic pulse_done;
    done = 1'b1;
    step;
    done = 1'b0;
  endtask

  // Accepts words until n_stop transfers have happened; records what was seen, judges nothing.
  task automatic run_frame(input bit rnd, input int n_stop);
    int cnt;
    bit held;
    logic signed [W-1:0] pd;
    logic [5:0] pi;
    logic ps;
    obs_dat.delete(); obs_sel.delete(); obs_idx.delete();
    obs_unstable = 0; obs_fd_early = 0; obs_gaps = 0; obs_cycles = 0; obs_timeout = 0;
    cnt = 0; held = 0; pd = '0; pi = '0; ps = 1'b0;
    while (cnt < n_stop && obs_cycles < 2000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) begin
        if (held && (out_data !== pd || out_index !== pi || out_sel !== ps)) obs_unstable++;
        if (frame_done) obs_fd_early++;
        if (out_ready) begin
          obs_dat.push_back(out_data);
          obs_sel.push_back(out_sel);
          obs_idx.push_back(out_index);
          cnt++;
          held = 0;
        end else begin
          held = 1; pd = out_data; pi = out_index; ps = out_sel;
        end
      end else begin
        obs_gaps++;
      end
      step;
      obs_cycles++;
    end
    if (cnt < n_stop) obs_timeout = 1;
    obs_fd_after    = frame_done;
    obs_valid_after = out_valid;
    obs_busy_after  = busy;
    if (n_stop == 96) begin
      step;
      obs_fd_next = frame_done;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || drop_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b busy=%b fd=%b drop=%b required all 0", out_valid, busy, frame_done, drop_err);
    end
    checks++;
    if (out_data !== '0 || out_index !== 6'd0 || out_sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: data=%0d idx=%0d sel=%b required 0/0/0", out_data, out_index, out_sel);
    end
    step; step;
    rst = 1'b0;
    step;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_stream;
    for (int c = 0; c < 32; c++) begin
      wr_R = 1'b1; wr_R_row_addr = 3'(c / 4); wr_R_col_addr = 2'(c % 4);
      wr_R_data = W'(c + 1); mr[c] = W'(c + 1);
      for (int k = 0; k < 8; k++) begin
        q_we[k] = (c < 8); q_adr[k] = 3'(c); q_dat[k] = W'(-(k * 8 + c + 1));
        if (c < 8) mq[k * 8 + c] = W'(-(k * 8 + c + 1));
      end
      done = (c == 31);
      step;
    end
    clear_strobes;
    done = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1 || out_index !== 6'd0 || out_sel !== 1'b0) begin
      errors++;
      $display("FAIL stream_start: valid=%b busy=%b idx=%0d sel=%b required 1/1/0/0", out_valid, busy, out_index, out_sel);
    end
    run_frame(1'b0, 96);
    checks++;
    if (obs_timeout != 0 || obs_cycles != 96 || obs_gaps != 0) begin
      errors++;
      $display("FAIL stream_count: timeout=%0d cycles=%0d gaps=%0d required 0/96/0", obs_timeout, obs_cycles, obs_gaps);
    end
    for (int i = 0; i < obs_dat.size(); i++) begin
      checks++;
      if (obs_dat[i] !== (i < 32 ? W'(i + 1) : W'(-(i - 31))) || obs_sel[i] !== (i >= 32) ||
          obs_idx[i] !== (i < 32 ? 6'(i) : 6'(i - 32))) begin
        errors++;
        $display("FAIL stream_word[%0d]: data=%0d sel=%b idx=%0d required %0d/%b/%0d", i, obs_dat[i], obs_sel[i],
                 obs_idx[i], (i < 32 ? i + 1 : -(i - 31)), (i >= 32), (i < 32 ? i : i - 32));
      end
    end
    checks++;
    if (obs_fd_after !== 1'b1 || obs_valid_after !== 1'b0 || obs_busy_after !== 1'b0 || obs_fd_next !== 1'b0 || obs_fd_early != 0) begin
      errors++;
      $display("FAIL stream_fin: fd=%b valid=%b busy=%b fd_next=%b early=%0d required 1/0/0/0/0",
               obs_fd_after, obs_valid_after, obs_busy_after, obs_fd_next, obs_fd_early);
    end
  endtask

  task automatic test_same_addr;
    for (int k = 0; k < 8; k++) begin
      q_we[k] = 1'b1; q_adr[k] = 3'd5; q_dat[k] = W'($urandom);
      mq[k * 8 + 5] = q_dat[k];
    end
    step;
    clear_strobes;
    pulse_done;
    run_frame(1'b0, 96);
    checks++;
    if (obs_timeout != 0 || obs_dat.size() != 96) begin
      errors++;
      $display("FAIL same_addr_count: timeout=%0d words=%0d required 0/96", obs_timeout, obs_dat.size());
    end
    for (int i = 0; i < obs_dat.size(); i++) begin
      checks++;
      if (obs_dat[i] !== (i < 32 ? mr[i] : mq[i - 32])) begin
        errors++;
        $display("FAIL same_addr_word[%0d]: data=%0d required %0d", i, obs_dat[i], (i < 32 ? mr[i] : mq[i - 32]));
      end
    end
  endtask

  task automatic test_backpressure;
    int vseen;
    rand_writes(20);
    done = 1'b1;
    step;
    run_frame(1'b1, 96);
    checks++;
    if (obs_timeout != 0 || obs_unstable != 0 || obs_gaps != 0) begin
      errors++;
      $display("FAIL bp_flow: timeout=%0d unstable=%0d gaps=%0d required 0/0/0", obs_timeout, obs_unstable, obs_gaps);
    end
    for (int i = 0; i < obs_dat.size(); i++) begin
      checks++;
      if (obs_dat[i] !== (i < 32 ? mr[i] : mq[i - 32]) || obs_idx[i] !== (i < 32 ? 6'(i) : 6'(i - 32))) begin
        errors++;
        $display("FAIL bp_word[%0d]: data=%0d idx=%0d required %0d", i, obs_dat[i], obs_idx[i], (i < 32 ? mr[i] : mq[i - 32]));
      end
    end
    checks++;
    if (obs_fd_after !== 1'b1 || obs_fd_next !== 1'b0) begin
      errors++;
      $display("FAIL bp_fin: fd=%b fd_next=%b required 1/0", obs_fd_after, obs_fd_next);
    end
    vseen = 0;
    repeat (6) begin
      if (out_valid) vseen++;
      step;
    end
    checks++;
    if (vseen != 0) begin
      errors++;
      $display("FAIL bp_no_retrigger: valid_cycles=%0d required 0", vseen);
    end
    done = 1'b0;
    step;
  endtask

  task automatic test_drop;
    rand_writes(5);
    checks++;
    if (drop_err !== 1'b0) begin
      errors++;
      $display("FAIL drop_clear: drop_err=%b required 0", drop_err);
    end
    pulse_done;
    out_ready = 1'b0;
    wr_R = 1'b1; wr_R_row_addr = 3'd0; wr_R_col_addr = 2'd0; wr_R_data = ~mr[0];
    q_we[2] = 1'b1; q_adr[2] = 3'd1; q_dat[2] = ~mq[17];
    step;
    clear_strobes;
    checks++;
    if (drop_err !== 1'b1) begin
      errors++;
      $display("FAIL drop_set: drop_err=%b required 1", drop_err);
    end
    run_frame(1'b0, 96);
    for (int i = 0; i < obs_dat.size(); i++) begin
      checks++;
      if (obs_dat[i] !== (i < 32 ? mr[i] : mq[i - 32])) begin
        errors++;
        $display("FAIL drop_word[%0d]: data=%0d required %0d", i, obs_dat[i], (i < 32 ? mr[i] : mq[i - 32]));
      end
    end
    checks++;
    if (drop_err !== 1'b1 || obs_timeout != 0) begin
      errors++;
      $display("FAIL drop_sticky: drop_err=%b timeout=%0d required 1/0", drop_err, obs_timeout);
    end
  endtask

  task automatic test_reset_mid;
    int vseen, fdseen;
    rand_writes(10);
    pulse_done;
    run_frame(1'b1, 40);
    for (int i = 0; i < obs_dat.size(); i++) begin
      checks++;
      if (obs_dat[i] !== (i < 32 ? mr[i] : mq[i - 32])) begin
        errors++;
        $display("FAIL abort_word[%0d]: data=%0d required %0d", i, obs_dat[i], (i < 32 ? mr[i] : mq[i - 32]));
      end
    end
    done = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_index !== 6'd0 || out_data !== '0 || drop_err !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: valid=%b busy=%b idx=%0d data=%0d drop=%b fd=%b required all 0",
               out_valid, busy, out_index, out_data, drop_err, frame_done);
    end
    step; step;
    rst = 1'b0;
    clear_model;
    vseen = 0; fdseen = 0;
    repeat (6) begin
      if (out_valid) vseen++;
      if (frame_done) fdseen++;
      step;
    end
    checks++;
    if (vseen != 0 || fdseen != 0) begin
      errors++;
      $display("FAIL abort_hold_done: valid_cycles=%0d fd_cycles=%0d required 0/0", vseen, fdseen);
    end
    done = 1'b0;
    step;
    pulse_done;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart: valid=%b required 1", out_valid);
    end
    run_frame(1'b0, 96);
    for (int i = 0; i < obs_dat.size(); i++) begin
      checks++;
      if (obs_dat[i] !== (i < 32 ? mr[i] : mq[i - 32])) begin
        errors++;
        $display("FAIL abort_zero[%0d]: data=%0d required %0d", i, obs_dat[i], (i < 32 ? mr[i] : mq[i - 32]));
      end
    end
    checks++;
    if (obs_timeout != 0 || obs_fd_after !== 1'b1) begin
      errors++;
      $display("FAIL abort_fin: timeout=%0d fd=%b required 0/1", obs_timeout, obs_fd_after);
    end
  endtask

  initial begin
    rst = 1'b1; done = 1'b0; out_ready = 1'b0;
    wr_R = 1'b0; wr_R_data = '0; wr_R_row_addr = '0; wr_R_col_addr = '0;
    for (int k = 0; k < 8; k++) begin
      q_we[k] = 1'b0; q_dat[k] = '0; q_adr[k] = '0;
    end
    clear_model;
    test_reset;
    test_stream;
    test_same_addr;
    test_backpressure;
    test_drop;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/qr_result_drain.md
QR_RESULT_DRAIN -- requirements
Module: qr_result_drain

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 12, giving the data word width of R and Q elements.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port wr_R, input, 1 bit: R element write strobe from qr_cordic.
REQ-005 SHALL have port wr_R_data, input, OUT_WIDTH bits, signed: the R element value.
REQ-006 SHALL have port wr_R_row_addr, input, 3 bits: the R row.
REQ-007 SHALL have port wr_R_col_addr, input, 2 bits: the R column.
REQ-008 SHALL have ports wr_Q_k (k=1..8), input, 1 bit each: Q row-k write strobes.
REQ-009 SHALL have ports wr_Q_data_k (k=1..8), input, OUT_WIDTH bits signed each: the Q row-k values.
REQ-010 SHALL have ports wr_Q_addr_k (k=1..8), input, 3 bits each: the Q row-k column.
REQ-011 SHALL have port done, input, 1 bit: the qr_cordic valid (level).
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-013 SHALL have port out_valid, output, 1 bit: out_data holds a word.
REQ-014 SHALL have port out_data, output, OUT_WIDTH bits signed: the streamed element.
REQ-015 SHALL have port out_sel, output, 1 bit: 0 = R element, 1 = Q element.
REQ-016 SHALL have port out_index, output, 6 bits: the linear index within the selected matrix.
REQ-017 SHALL have port busy, output, 1 bit: high while draining.
REQ-018 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last transfer.
REQ-019 SHALL have port drop_err, output, 1 bit: sticky flag set when a write was ignored.

Function
REQ-020 SHALL hold R_MEM of 32 words, addressed at 4*row+col.
REQ-021 SHALL hold Q_MEM of 64 words; wr_Q_k SHALL write Q_MEM[(k-1)*8 + wr_Q_addr_k].
REQ-022 SHALL use a FSM with states CAPTURE, DRAIN_R, DRAIN_Q and FIN; the reset state is CAPTURE.
REQ-023 In CAPTURE, every asserted strobe (wr_R and up to eight wr_Q_k in the same cycle) SHALL write its word that cycle; the same address written in consecutive cycles keeps the last value.
REQ-024 On a done rising edge, where the previous done was sampled 0, in CAPTURE:
  - writes in that same cycle SHALL still be captured;
  - the next state SHALL be DRAIN_R, with the pointer at 0.
REQ-025 The done level held high SHALL NOT retrigger; a rising edge outside CAPTURE SHALL be ignored.
REQ-026 In DRAIN_R and DRAIN_Q, out_valid SHALL be 1 and out_data/out_sel/out_index SHALL reflect the current pointer.
  - out_valid rises the cycle after the done edge is sampled.
REQ-027 A transfer SHALL occur when out_valid && out_ready.
  - On a transfer, the pointer increments.
  - Without a transfer, all outputs SHALL hold stable.
REQ-028 Pointer wrap-around:
  - A transfer at R index 31 SHALL move to DRAIN_Q with index 0.
  - A transfer at Q index 63 SHALL move to FIN.
REQ-029 Stream order SHALL be R row-major 0..31, then Q row-major 0..63: exactly 96 transfers per frame.
REQ-030 FIN SHALL assert frame_done for exactly one cycle with out_valid=0, then return to CAPTURE.
REQ-031 Memory contents SHALL persist across frames; only written addresses change.
REQ-032 Any write strobe in DRAIN_R, DRAIN_Q or FIN SHALL be discarded and SHALL set drop_err, which stays set until rst.
REQ-033 busy SHALL be 1 exactly in DRAIN_R and DRAIN_Q.

Reset
REQ-034 When rst=1, immediately and regardless of state:
  - state SHALL be CAPTURE and the pointer 0;
  - out_valid, busy, frame_done and drop_err SHALL be 0;
  - out_data and out_index SHALL be 0, and out_sel SHALL be 0;
  - all R_MEM and Q_MEM words SHALL be 0;
  - the done edge history SHALL be 1, so a done held high through reset does not start a frame.
REQ-035 Reset asserted mid-drain SHALL abort the frame with no frame_done pulse.

Verification
REQ-036 Write R[i]=i+1 and Q[j]=-(j+1), pulse done, hold out_ready=1 -> 96 consecutive transfers:
  - out_data runs 1..32, then -1..-64;
  - out_sel switches after 32 transfers;
  - frame_done pulses 1 cycle after the 96th transfer.
REQ-037 Drive all eight wr_Q_k in one cycle at address 5 -> Q indices 5, 13, ..., 61 are all captured correctly.
REQ-038 Toggle out_ready randomly during the drain -> no word is lost or duplicated, and outputs are stable while out_ready=0.
REQ-039 Pulse wr_R during DRAIN_R -> drop_err=1 and the streamed data is unchanged.
REQ-040 Assert rst at transfer 40 -> out_valid=0 at once, and the memory reads 0.
  - A new frame with done held high through reset does not start until done falls and rises again.
